// File: rtl/mem_test_sequencer_if.sv
// Request channel between the test sequencer and the transaction generator.
// The sequencer is the master; the generator answers with trans_ready.
interface mem_test_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             trans_valid;
  logic             trans_ready;
  logic             trans_op;
  logic [CNT_W-1:0] trans_num;

  modport master (
    output trans_valid,
    output trans_op,
    output trans_num,
    input  trans_ready
  );

  modport slave (
    input  trans_valid,
    input  trans_op,
    input  trans_num,
    output trans_ready
  );
endinterface

// File: rtl/mem_test_sequencer.sv
// Memory checker test controller: runs the write and/or read phases selected at
// start, issues one request per handshake, tracks outstanding reads, aborts on compare error.
module mem_test_sequencer #(
  parameter int CNT_W   = 32,
  parameter int OUTST_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         test_mode_i,
  input  logic [CNT_W-1:0]   trans_amount_i,
  mem_test_sequencer_if.master trans_if,
  input  logic               wr_idle_i,
  input  logic               rd_cmpl_i,
  input  logic               cmp_error_i,
  output logic               busy_o,
  output logic               test_done_o,
  output logic               test_error_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ISSUE = 3'd1;
  localparam logic [2:0] S_WR_DRAIN = 3'd2;
  localparam logic [2:0] S_RD_ISSUE = 3'd3;
  localparam logic [2:0] S_RD_DRAIN = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;

  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

  logic [2:0]         state_q,  state_d;
  logic [1:0]         mode_q,   mode_d;
  logic [CNT_W-1:0]   amount_q, amount_d;
  logic [CNT_W-1:0]   num_q,    num_d;
  logic [OUTST_W-1:0] outst_q,  outst_d;
  logic               valid_q,  valid_d;
  logic               op_q,     op_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               error_q,  error_d;
  logic               abort_q,  abort_d;

  logic hs;
  logic last_hs;
  logic rd_inc;
  logic rd_dec;
  logic leave_issue;
  logic issue_ok;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    mode_d   = mode_q;
    amount_d = amount_q;
    num_d    = num_q;
    error_d  = error_q;
    abort_d  = abort_q;
    outst_d  = outst_q;

    hs      = valid_q & trans_if.trans_ready;
    last_hs = hs && (num_q == amount_q - 1'b1);
    rd_inc  = hs & ~op_q;
    rd_dec  = rd_cmpl_i & (outst_q != '0);

    if (rd_inc && !rd_dec) begin
      outst_d = outst_q + 1'b1;
    end else if (rd_dec && !rd_inc) begin
      outst_d = outst_q - 1'b1;
    end

    if (hs) begin
      num_d = num_q + 1'b1;
    end

    if (state_q != S_IDLE && cmp_error_i) begin
      error_d = 1'b1;
      abort_d = 1'b1;
    end

    // An abort never cuts a pending request short: leave only once nothing is in flight.
    leave_issue = last_hs || (abort_d && (hs || !valid_q));

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d   = test_mode_i;
          amount_d = trans_amount_i;
          num_d    = '0;
          error_d  = 1'b0;
          abort_d  = 1'b0;
          if (test_mode_i == MODE_NONE) begin
            error_d = 1'b1;
            state_d = S_FINISH;
          end else if (trans_amount_i == '0) begin
            state_d = S_FINISH;
          end else if (test_mode_i == MODE_READ) begin
            state_d = S_RD_ISSUE;
          end else begin
            state_d = S_WR_ISSUE;
          end
        end
      end
      S_WR_ISSUE: begin
        if (leave_issue) begin
          num_d   = '0;
          state_d = S_WR_DRAIN;
        end
      end
      S_WR_DRAIN: begin
        if (wr_idle_i) begin
          state_d = (abort_d || mode_q == MODE_WRITE) ? S_FINISH : S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        if (leave_issue) begin
          num_d   = '0;
          state_d = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Judge read room on the next-cycle count so a raised read can always complete.
    issue_ok = !abort_d && (state_d == S_WR_ISSUE || outst_d != OUTST_MAX);

    if (valid_q && !hs) begin
      valid_d = 1'b1;
    end else begin
      valid_d = (state_d == S_WR_ISSUE || state_d == S_RD_ISSUE) && issue_ok;
    end

    op_d   = valid_d && (state_d == S_WR_ISSUE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FINISH);
  end

  // NOTE: sequential state updates use non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_NONE;
      amount_q <= '0;
      num_q    <= '0;
      outst_q  <= '0;
      valid_q  <= 1'b0;
      op_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      amount_q <= amount_d;
      num_q    <= num_d;
      outst_q  <= outst_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      abort_q  <= abort_d;
    end
  end

  assign trans_if.trans_valid = valid_q;
  assign trans_if.trans_op    = op_q;
  assign trans_if.trans_num   = num_q;
  assign busy_o               = busy_q;
  assign test_done_o          = done_q;
  assign test_error_o         = error_q;

endmodule

// File: doc/mem_test_sequencer.md
Name: mem_test_sequencer

Overview:
- Top-level test controller for the memory checker. Sits between the CSR block and the transaction generator / compare unit, in the system clock domain.
- On start it runs the phases selected by test_mode (write phase, read phase, or write-then-check).
- In each phase it issues the configured number of transaction requests over a valid/ready handshake.
- It tracks outstanding reads, aborts on a compare error, and reports done, busy and error status.

Parameters:
- CNT_W, 32: width of the transaction amount and of the transaction index counters.
- OUTST_W, 8: width of the outstanding-read counter. Maximum outstanding reads = 2^OUTST_W-1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  start pulse; accepted only in IDLE
- test_mode_i  in  2  01 READ_ONLY, 10 WRITE_ONLY, 11 WRITE_AND_CHECK; sampled on an accepted start
- trans_amount_i  in  CNT_W  transactions per phase; sampled on an accepted start
- trans_valid_o  out  1  transaction request valid
- trans_ready_i  in  1  generator accepts the request
- trans_op_o  out  1  1 = write, 0 = read
- trans_num_o  out  CNT_W  index of the current request within its phase
- wr_idle_i  in  1  write datapath drained (no pending Avalon writes)
- rd_cmpl_i  in  1  one read transaction fully returned and checked
- cmp_error_i  in  1  compare mismatch pulse
- busy_o  out  1  state != IDLE
- test_done_o  out  1  one-cycle pulse at test end
- test_error_o  out  1  sticky error; cleared on the next accepted start

Behaviour:
- Reset values (async, all registers): state = IDLE; trans_valid_o, trans_op_o, trans_num_o, busy_o, test_done_o, test_error_o all 0; outstanding counter 0; error/abort flag 0.
- States: IDLE, WR_ISSUE, WR_DRAIN, RD_ISSUE, RD_DRAIN, FINISH.
- IDLE + start_i:
  - Latch mode and amount; clear test_error_o and the issue counter.
  - mode 00 → FINISH with test_error_o=1.
  - amount == 0 → FINISH, no requests issued.
  - mode 01 → RD_ISSUE; mode 10 or 11 → WR_ISSUE.
- Phase sequences:
  - WRITE_ONLY: WR_ISSUE → WR_DRAIN → FINISH.
  - WRITE_AND_CHECK: WR_ISSUE → WR_DRAIN → RD_ISSUE → RD_DRAIN → FINISH.
  - READ_ONLY: RD_ISSUE → RD_DRAIN → FINISH.
- start_i outside IDLE is ignored.
- trans_valid_o is registered.
  - It asserts in a *_ISSUE state when issuing is allowed.
  - Once asserted it stays high, with trans_op_o and trans_num_o stable, until a handshake (valid & ready).
  - Handshake → index++. The next request's valid may assert in the cycle after the handshake. There is no back-to-back guarantee.
  - Handshake on index amount-1 → leave the issue state next cycle; valid = 0; index resets to 0 for the next phase.
- Read issuing is blocked while outstanding == 2^OUTST_W-1 (full).
- Outstanding counter:
  - +1 on a read handshake; -1 on rd_cmpl_i.
  - Both in the same cycle → unchanged.
  - rd_cmpl_i at 0 → ignored, no underflow.
- WR_DRAIN: wait for wr_idle_i=1, sampled no earlier than the cycle after entry, then advance.
- RD_DRAIN: wait for outstanding == 0, then FINISH.
- cmp_error_i in any non-IDLE state:
  - Set test_error_o and the abort flag.
  - No new request is raised; a request already valid completes its handshake.
  - From RD_ISSUE, go to RD_DRAIN after any pending handshake.
  - cmp_error_i in IDLE is ignored.
- FINISH: test_done_o=1 for exactly one cycle, then IDLE. busy_o drops in the same cycle as IDLE entry.
- Reset mid-test: immediate return to IDLE; all outputs take their reset values; no done pulse.

Test Plan:
- mode 11, amount 4, ready always 1, rd_cmpl 3 cycles after each read → 4 writes with num 0..3 and op=1; WR_DRAIN waits for wr_idle; then 4 reads with op=0; done pulse after the 4th rd_cmpl; test_error_o=0.
- mode 10, amount 3, ready held low 5 cycles on req 1 → valid, op and num=1 stable for all 5 cycles; exactly 3 handshakes; no reads issued; done after wr_idle_i=1.
- mode 01, amount 300, OUTST_W=8, rd_cmpl never asserted → exactly 255 read handshakes, then valid stays 0. Release rd_cmpl pulses → remaining 45 issue; done when outstanding reaches 0.
- mode 01, amount 10, cmp_error_i pulse after 3rd handshake while 4th valid → 4th completes; no 5th request; done once outstanding reaches 0; test_error_o=1 until the next start.
- amount 0 or mode 00 → done pulse 2 cycles after start with no valid; test_error_o=0 for amount 0, 1 for mode 00.
- rst_i asserted during RD_ISSUE with outstanding=5 → all outputs 0 asynchronously. A subsequent start runs cleanly: first request num=0, outstanding starts at 0.
